// File: rtl/gpio_seq_pkg.sv
// Shared register map, control/status bit positions and sequencer state
// encoding for the gpio pattern sequencer.
package gpio_seq_pkg;

  localparam logic [3:0] REG_CTRL      = 4'h0;
  localparam logic [3:0] REG_STATUS    = 4'h1;
  localparam logic [3:0] REG_PERIOD_LO = 4'h2;
  localparam logic [3:0] REG_PERIOD_HI = 4'h3;
  localparam logic [3:0] REG_LENGTH    = 4'h4;
  localparam logic [3:0] REG_DIRECT    = 4'h5;
  localparam logic [3:0] REG_PAT_BASE  = 4'h8;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_LOOP    = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } seq_state_e;

endpackage

// File: rtl/gpio_seq_timer.sv
// Dwell down-counter: loads a period, counts down while enabled and
// parks at zero, flagging zero combinationally.
module gpio_seq_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_load,
  input  logic [PERIOD_W-1:0] i_load_val,
  input  logic                i_en,
  output logic                o_zero
);

  logic [PERIOD_W-1:0] r_cnt;

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - PERIOD_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gpio_seq_ctrl.sv
// CPU-programmable gpio pattern sequencer: register file, pattern table,
// IDLE/LOAD/DWELL FSM and the direct/sequencer output mux.
module gpio_seq_ctrl
  import gpio_seq_pkg::*;
#(
  parameter int NUM_PINS = 8,
  parameter int DEPTH    = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bus_cs,
  input  logic                bus_we,
  input  logic [3:0]          bus_addr,
  input  logic [7:0]          bus_wdata,
  output logic [7:0]          bus_rdata,
  output logic                gpio_cs,
  output logic [NUM_PINS-1:0] gpio_data
);

  localparam int IDX_W = $clog2(DEPTH);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic                r_run;
  logic                r_loop;
  logic                r_done;
  logic [PERIOD_W-1:0] r_period;
  logic [IDX_W-1:0]    r_length;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_PINS-1:0] r_pat [DEPTH];
  logic                r_gpio_cs;
  logic [NUM_PINS-1:0] r_gpio_data;
  logic [7:0]          r_rdata;

  logic                w_wr;
  logic                w_rd;
  logic                w_ctrl_wr;
  logic                w_direct_wr;
  logic                w_start;
  logic                w_stop;
  logic                w_pat_hit;
  logic [IDX_W-1:0]    w_pat_idx;
  logic                w_last;
  logic                w_zero;
  logic                w_busy;
  logic                w_start_run;
  logic                w_seq_fire;
  logic                w_decide;
  logic                w_finish;
  logic                w_timer_en;
  logic [7:0]          w_rdata;

  assign w_wr        = bus_cs & bus_we;
  assign w_rd        = bus_cs & ~bus_we;
  assign w_ctrl_wr   = w_wr && (bus_addr == REG_CTRL);
  assign w_direct_wr = w_wr && (bus_addr == REG_DIRECT);
  assign w_start     = w_ctrl_wr & bus_wdata[CTRL_RUN];
  assign w_stop      = w_ctrl_wr & ~bus_wdata[CTRL_RUN];
  assign w_pat_hit   = bus_addr[3] && ({1'b0, bus_addr[2:0]} < 4'(DEPTH));
  assign w_pat_idx   = bus_addr[IDX_W-1:0];
  // A lowered LENGTH may leave idx beyond it; treat that as the last step too.
  assign w_last      = (r_idx >= r_length);
  assign w_busy      = (r_state != ST_IDLE);

  gpio_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_seq_fire),
    .i_load_val (r_period),
    .i_en       (w_timer_en),
    .o_zero     (w_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a stop request overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_LOAD;
        else         w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_stop)           w_state_nxt = ST_IDLE;
        else if (w_direct_wr) w_state_nxt = ST_LOAD;
        else                  w_state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        if (w_stop)                          w_state_nxt = ST_IDLE;
        else if (w_zero && w_last && !r_loop) w_state_nxt = ST_IDLE;
        else if (w_zero)                     w_state_nxt = ST_LOAD;
        else                                 w_state_nxt = ST_DWELL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: sequencer fire, end-of-dwell decision and run completion.
  always_comb begin
    w_start_run = 1'b0;
    w_seq_fire  = 1'b0;
    w_decide    = 1'b0;
    w_finish    = 1'b0;
    w_timer_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_run = w_start;
      end
      ST_LOAD: begin
        w_seq_fire = ~w_stop & ~w_direct_wr;
      end
      ST_DWELL: begin
        w_timer_en = 1'b1;
        w_decide   = w_zero & ~w_stop;
        w_finish   = w_zero & ~w_stop & w_last & ~r_loop;
      end
      default: begin
        w_start_run = 1'b0;
      end
    endcase
  end

  // Step index and completion flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_start_run) begin
        r_idx  <= '0;
        r_done <= 1'b0;
      end else if (w_decide) begin
        r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
        r_done <= w_finish;
      end
    end
  end

  // Register file and pattern table writes; completion clears RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_loop   <= 1'b0;
      r_period <= '0;
      r_length <= '0;
      for (int i = 0; i < DEPTH; i++) r_pat[i] <= '0;
    end else begin
      if (w_finish) begin
        r_run <= 1'b0;
      end else if (w_ctrl_wr) begin
        r_run <= bus_wdata[CTRL_RUN];
      end
      if (w_ctrl_wr) r_loop <= bus_wdata[CTRL_LOOP];
      if (w_wr && (bus_addr == REG_PERIOD_LO)) r_period[7:0]  <= bus_wdata;
      if (w_wr && (bus_addr == REG_PERIOD_HI)) r_period[15:8] <= bus_wdata;
      if (w_wr && (bus_addr == REG_LENGTH))    r_length <= bus_wdata[IDX_W-1:0];
      if (w_wr && w_pat_hit)                   r_pat[w_pat_idx] <= bus_wdata[NUM_PINS-1:0];
    end
  end

  // Read data mux.
  always_comb begin
    w_rdata = 8'h00;
    if (w_pat_hit) begin
      w_rdata = 8'(r_pat[w_pat_idx]);
    end else begin
      case (bus_addr)
        REG_CTRL:      w_rdata = {6'b000000, r_loop, r_run};
        REG_STATUS:    w_rdata = {1'b0, 3'(r_idx), 2'b00, r_done, w_busy};
        REG_PERIOD_LO: w_rdata = r_period[7:0];
        REG_PERIOD_HI: w_rdata = r_period[15:8];
        REG_LENGTH:    w_rdata = 8'(r_length);
        default:       w_rdata = 8'h00;
      endcase
    end
  end

  // Registered bus read data and gpio strobe/data; direct writes win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata     <= 8'h00;
      r_gpio_cs   <= 1'b0;
      r_gpio_data <= '0;
    end else begin
      if (w_rd) r_rdata <= w_rdata;
      r_gpio_cs <= w_direct_wr | w_seq_fire;
      if (w_direct_wr) begin
        r_gpio_data <= bus_wdata[NUM_PINS-1:0];
      end else if (w_seq_fire) begin
        r_gpio_data <= r_pat[r_idx];
      end
    end
  end

  assign bus_rdata = r_rdata;
  assign gpio_cs   = r_gpio_cs;
  assign gpio_data = r_gpio_data;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Directed self-checking bench for gpio_seq_ctrl; pulses are logged with the
// index of the clock edge that produced them.
module tb_gpio_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bus_cs;
  logic       bus_we;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       gpio_cs;
  logic [7:0] gpio_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int pulse_t[$];
  logic [7:0] pulse_d[$];

  gpio_seq_ctrl #(.NUM_PINS(8), .DEPTH(4), .PERIOD_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .gpio_cs   (gpio_cs),
    .gpio_data (gpio_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gpio_cs === 1'b1) begin
      pulse_t.push_back(cyc);
      pulse_d.push_back(gpio_data);
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_cs = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_cs = 1'b0;
    d = bus_rdata;
  endtask

  task automatic clear_pulses();
    pulse_t.delete();
    pulse_d.delete();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [3:0] regs [8];
    regs[0] = 4'h0; regs[1] = 4'h1; regs[2] = 4'h2; regs[3] = 4'h3;
    regs[4] = 4'h4; regs[5] = 4'h8; regs[6] = 4'h9; regs[7] = 4'hA;
    wr(4'h8, 8'h5A); wr(4'h9, 8'hA5); wr(4'h4, 8'h01); wr(4'h2, 8'h02);
    wr(4'h0, 8'h03);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (gpio_cs !== 1'b0 || gpio_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got cs=%b data=%h, want cs=0 data=00", gpio_cs, gpio_data);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(regs[i], d);
      tests_run++;
      if (d !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_reg_%h: got %h, want 00", regs[i], d);
      end
    end
    clear_pulses();
    repeat (10) @(negedge clk);
    tests_run++;
    if (pulse_t.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_no_pulses: got %0d pulses, want 0", pulse_t.size());
    end
  endtask

  task automatic test_direct();
    int w;
    clear_pulses();
    wr(4'h5, 8'hA5);
    w = cyc;
    repeat (4) @(negedge clk);
    tests_run++;
    if (pulse_t.size() != 1 || pulse_t[0] != w || pulse_d[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL direct_pulse: got n=%0d t0=%0d d0=%h, want n=1 t0=%0d d0=a5",
               pulse_t.size(), (pulse_t.size() > 0) ? pulse_t[0] - w : -1,
               (pulse_d.size() > 0) ? pulse_d[0] : 8'hxx, 0);
    end
  endtask

  task automatic test_one_shot();
    int w;
    logic [7:0] d;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h04; exp_d[3] = 8'h08;
    for (int i = 0; i < 4; i++) wr(4'h8 + 4'(i), exp_d[i]);
    wr(4'h4, 8'h03); wr(4'h2, 8'h03); wr(4'h3, 8'h00);
    clear_pulses();
    wr(4'h0, 8'h01);
    w = cyc;
    rd(4'h1, d);
    tests_run++;
    if (d[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL oneshot_busy: got STATUS=%h, want BUSY=1", d);
    end
    repeat (24) @(negedge clk);
    tests_run++;
    if (pulse_t.size() != 4) begin
      tests_failed++;
      $display("FAIL oneshot_count: got %0d pulses, want 4", pulse_t.size());
    end
    for (int i = 0; i < 4 && i < pulse_t.size(); i++) begin
      tests_run++;
      if (pulse_t[i] != w + 1 + 5 * i || pulse_d[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL oneshot_pulse%0d: got t=+%0d d=%h, want t=+%0d d=%h",
                 i, pulse_t[i] - w, pulse_d[i], 1 + 5 * i, exp_d[i]);
      end
    end
    rd(4'h1, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++;
      $display("FAIL oneshot_status: got %h, want 02", d);
    end
    rd(4'h0, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL oneshot_ctrl: got %h, want 00", d);
    end
  endtask

  task automatic test_loop_stop();
    int w;
    logic [7:0] d;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    wr(4'h8, 8'h11); wr(4'h9, 8'h22); wr(4'h4, 8'h01);
    wr(4'h2, 8'h00); wr(4'h3, 8'h00);
    clear_pulses();
    wr(4'h0, 8'h03);
    w = cyc;
    repeat (6) @(negedge clk);
    // Stop lands on the edge where the FSM would otherwise fire its 4th pulse.
    wr(4'h0, 8'h00);
    repeat (10) @(negedge clk);
    tests_run++;
    if (pulse_t.size() != 3) begin
      tests_failed++;
      $display("FAIL loop_count: got %0d pulses, want 3", pulse_t.size());
    end
    for (int i = 0; i < 3 && i < pulse_t.size(); i++) begin
      tests_run++;
      if (pulse_t[i] != w + 1 + 2 * i || pulse_d[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL loop_pulse%0d: got t=+%0d d=%h, want t=+%0d d=%h",
                 i, pulse_t[i] - w, pulse_d[i], 1 + 2 * i, exp_d[i]);
      end
    end
    tests_run++;
    if (gpio_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL stop_hold: got %h, want 11", gpio_data);
    end
    rd(4'h1, d);
    tests_run++;
    if (d[1:0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL stop_status: got busy/done=%b, want 00", d[1:0]);
    end
  endtask

  task automatic test_collision();
    int w;
    int exp_t [3];
    logic [7:0] exp_d [3];
    exp_t[0] = 1; exp_t[1] = 2; exp_t[2] = 7;
    exp_d[0] = 8'hFF; exp_d[1] = 8'h01; exp_d[2] = 8'h02;
    wr(4'h8, 8'h01); wr(4'h9, 8'h02); wr(4'h4, 8'h01); wr(4'h2, 8'h03);
    clear_pulses();
    wr(4'h0, 8'h01);
    w = cyc;
    wr(4'h5, 8'hFF);
    repeat (15) @(negedge clk);
    tests_run++;
    if (pulse_t.size() != 3) begin
      tests_failed++;
      $display("FAIL collide_count: got %0d pulses, want 3", pulse_t.size());
    end
    for (int i = 0; i < 3 && i < pulse_t.size(); i++) begin
      tests_run++;
      if (pulse_t[i] != w + exp_t[i] || pulse_d[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL collide_pulse%0d: got t=+%0d d=%h, want t=+%0d d=%h",
                 i, pulse_t[i] - w, pulse_d[i], exp_t[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_live_update();
    int w;
    int exp_t [3];
    logic [7:0] exp_d [3];
    exp_t[0] = 1; exp_t[1] = 6; exp_t[2] = 15;
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h40;
    wr(4'h8, 8'h10); wr(4'h9, 8'h20); wr(4'hA, 8'h40);
    wr(4'h4, 8'h02); wr(4'h2, 8'h03);
    clear_pulses();
    wr(4'h0, 8'h01);
    w = cyc;
    wr(4'h2, 8'h07);
    repeat (25) @(negedge clk);
    tests_run++;
    if (pulse_t.size() != 3) begin
      tests_failed++;
      $display("FAIL live_count: got %0d pulses, want 3", pulse_t.size());
    end
    for (int i = 0; i < 3 && i < pulse_t.size(); i++) begin
      tests_run++;
      if (pulse_t[i] != w + exp_t[i] || pulse_d[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL live_pulse%0d: got t=+%0d d=%h, want t=+%0d d=%h",
                 i, pulse_t[i] - w, pulse_d[i], exp_t[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_regmap();
    logic [7:0] d;
    logic [3:0] addrs [6];
    logic [7:0] exp [6];
    wr(4'h4, 8'hFF);
    wr(4'h6, 8'hFF);
    addrs[0] = 4'h2; exp[0] = 8'h07;
    addrs[1] = 4'h4; exp[1] = 8'h03;
    addrs[2] = 4'h5; exp[2] = 8'h00;
    addrs[3] = 4'h6; exp[3] = 8'h00;
    addrs[4] = 4'hA; exp[4] = 8'h40;
    addrs[5] = 4'hC; exp[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], d);
      tests_run++;
      if (d !== exp[i]) begin
        tests_failed++;
        $display("FAIL regmap_%h: got %h, want %h", addrs[i], d, exp[i]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_direct();
    test_one_shot();
    test_loop_stop();
    test_collision();
    test_live_update();
    test_regmap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
